burst_line_master: RTL and testbench

Initiator for the team's burst-RAM command interface: converts single-request cache-line reads and writes into one burst command plus BurstDataCount data beats. It sits between the cache controller (upstream, valid/ready request, registered response) and the burst RAM (PSRAM IP or its simulation model). It also provides calibration gating, line assembly and disassembly, and a read timeout.

---
 rtl/burst_line_pkg.sv | 18 +
 rtl/burst_line_master.sv | 203 ++++++++++++++++++++
 tb/tb_burst_line_master.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_line_pkg.sv
// Shared types and command encodings for the burst-RAM line master and its RAM model.
// Latency: none (declarations only).
// Backpressure: not applicable.
package burst_line_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_CALIB,
        ST_IDLE,
        ST_WRITE_BURST,
        ST_READ_WAIT,
        ST_READ_BURST,
        ST_SETTLE
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_line_master.sv
// Turns one cache-line read/write request into a burst command plus BurstDataCount beats.
// Latency: cmd one cycle after accept; write resp at cmd+BurstDataCount, read resp one cycle after last beat.
// Backpressure: req_ready only in Idle with RAM calibrated and not busy; one request in flight.
module burst_line_master
    import burst_line_pkg::*;
#(
    parameter int DataBitWidth    = 64,
    parameter int AddressBitWidth = 4,
    parameter int BurstDataCount  = 4,
    parameter int TimeoutCycles   = 255,
    localparam int LineBits       = DataBitWidth * BurstDataCount,
    localparam int LineAddrBits   = AddressBitWidth - $clog2(BurstDataCount)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [LineAddrBits-1:0]     req_addr,
    input  logic [LineBits-1:0]         req_wr_line,
    output logic                        resp_valid,
    output logic                        resp_write,
    output logic                        resp_error,
    output logic [LineBits-1:0]         resp_rd_line,
    output logic                        br_cmd,
    output logic                        br_cmd_en,
    output logic [AddressBitWidth-1:0]  br_addr,
    output logic [DataBitWidth-1:0]     br_wr_data,
    output logic [DataBitWidth/8-1:0]   br_data_mask,
    input  logic [DataBitWidth-1:0]     br_rd_data,
    input  logic                        br_rd_data_valid,
    input  logic                        br_init_calib,
    input  logic                        br_busy
);

    localparam int BeatBits = $clog2(BurstDataCount);
    localparam int TmoBits  = $clog2(TimeoutCycles + 1);
    localparam logic [BeatBits-1:0] BeatLast = BeatBits'(BurstDataCount - 1);
    localparam logic [TmoBits-1:0]  TmoLimit = TmoBits'(TimeoutCycles);

    state_e                 state;
    state_e                 state_nxt;
    logic                   accept;
    logic                   wr_advance;
    logic                   rd_capture;
    logic                   tmo_run;
    logic                   timeout_hit;
    logic [BeatBits-1:0]    beat_cnt;
    logic [TmoBits-1:0]     tmo_cnt;
    logic [LineBits-1:0]    wr_shift;

    // Every byte of every beat is always written.
    assign br_data_mask = '0;

    // Settle is the single response cycle.
    assign resp_valid = (state == ST_SETTLE);

    // State register; reset aborts any burst in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_CALIB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the per-cycle strobes that steer the datapath.
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        accept      = 1'b0;
        wr_advance  = 1'b0;
        rd_capture  = 1'b0;
        tmo_run     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_WAIT_CALIB: begin
                if (br_init_calib) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (br_init_calib && !br_busy) begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        accept    = 1'b1;
                        state_nxt = req_write ? ST_WRITE_BURST : ST_READ_WAIT;
                    end
                end
            end
            ST_WRITE_BURST: begin
                // One beat per cycle; the cmd cycle already carries beat 0.
                if (beat_cnt == BeatLast) begin
                    state_nxt = ST_SETTLE;
                end else begin
                    wr_advance = 1'b1;
                end
            end
            ST_READ_WAIT: begin
                // A beat arriving on the limit cycle still counts as in time.
                if (br_rd_data_valid) begin
                    rd_capture = 1'b1;
                    state_nxt  = ST_READ_BURST;
                end else if (tmo_cnt == TmoLimit) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_SETTLE;
                end else begin
                    tmo_run = 1'b1;
                end
            end
            ST_READ_BURST: begin
                // Beats are counted, so gaps in rd_data_valid are harmless.
                if (br_rd_data_valid) begin
                    rd_capture = 1'b1;
                    if (beat_cnt == BeatLast) begin
                        state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                // Gives the RAM's registered busy time to reflect the finished burst.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_WAIT_CALIB;
            end
        endcase
    end

    // Command strobe and command fields, presented the cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cmd_en <= 1'b0;
            br_cmd    <= CMD_READ;
            br_addr   <= '0;
        end else begin
            br_cmd_en <= accept;
            if (accept) begin
                br_cmd  <= req_write ? CMD_WRITE : CMD_READ;
                br_addr <= {req_addr, {BeatBits{1'b0}}};
            end
        end
    end

    // Write line disassembly: word 0 goes out with the cmd, the rest shift down one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_wr_data <= '0;
            wr_shift   <= '0;
        end else if (accept) begin
            br_wr_data <= req_wr_line[DataBitWidth-1:0];
            wr_shift   <= req_wr_line >> DataBitWidth;
        end else if (wr_advance) begin
            br_wr_data <= wr_shift[DataBitWidth-1:0];
            wr_shift   <= wr_shift >> DataBitWidth;
        end
    end

    // Beat counter shared by write beats and captured read beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= '0;
        end else if (wr_advance || rd_capture) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // First-beat timeout counter; counts cycles spent in ReadWait from the cmd cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (tmo_run) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Read line assembly: beats shift in from the top so beat 0 lands in word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rd_line <= '0;
        end else if (rd_capture) begin
            resp_rd_line <= {br_rd_data, resp_rd_line[LineBits-1:DataBitWidth]};
        end
    end

    // Response qualifiers, latched at accept and flagged on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_write <= 1'b0;
            resp_error <= 1'b0;
        end else if (accept) begin
            resp_write <= req_write;
            resp_error <= 1'b0;
        end else if (timeout_hit) begin
            resp_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_burst_line_master.sv
// Directed bench for burst_line_master with a behavioural burst-RAM model.
// Latency: RAM model read latency and beat gaps are controlled from the stimulus.
// Backpressure: RAM model raises busy one cycle after each cmd until its burst is done.
module tb_burst_line_master;
    import burst_line_pkg::*;

    localparam int DW  = 64;
    localparam int AW  = 4;
    localparam int BDC = 4;
    localparam int TMO = 20;
    localparam int LB  = DW * BDC;
    localparam int LAB = AW - $clog2(BDC);

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [LAB-1:0]  req_addr;
    logic [LB-1:0]   req_wr_line;
    logic            resp_valid;
    logic            resp_write;
    logic            resp_error;
    logic [LB-1:0]   resp_rd_line;
    logic            br_cmd;
    logic            br_cmd_en;
    logic [AW-1:0]   br_addr;
    logic [DW-1:0]   br_wr_data;
    logic [DW/8-1:0] br_data_mask;
    logic [DW-1:0]   br_rd_data;
    logic            br_rd_data_valid;
    logic            br_init_calib;
    logic            br_busy;

    int checks;
    int errors;
    int cyc;
    int ram_lat;
    bit ram_mute;
    bit ram_gap;
    int cmd_en_total;
    int overlap_cmd;
    logic [DW-1:0] mem [16];

    burst_line_master #(
        .DataBitWidth   (DW),
        .AddressBitWidth(AW),
        .BurstDataCount (BDC),
        .TimeoutCycles  (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wr_line     (req_wr_line),
        .resp_valid      (resp_valid),
        .resp_write      (resp_write),
        .resp_error      (resp_error),
        .resp_rd_line    (resp_rd_line),
        .br_cmd          (br_cmd),
        .br_cmd_en       (br_cmd_en),
        .br_addr         (br_addr),
        .br_wr_data      (br_wr_data),
        .br_data_mask    (br_data_mask),
        .br_rd_data      (br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .br_init_calib   (br_init_calib),
        .br_busy         (br_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    // Burst RAM model: observes DUT outputs mid-cycle, drives the next cycle just after the edge.
    initial begin : ram_model
        int mode;
        int t;
        int b;
        bit gap_done;
        logic [AW-1:0] base;
        bit nxt_busy;
        bit nxt_vld;
        logic [DW-1:0] nxt_dat;
        mode = 0; t = 0; b = 0; gap_done = 0; base = '0;
        cmd_en_total = 0; overlap_cmd = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        br_busy = 1'b0; br_rd_data_valid = 1'b0; br_rd_data = '0;
        forever begin
            @(negedge clk);
            nxt_busy = 1'b0; nxt_vld = 1'b0; nxt_dat = '0;
            if (!rst_n) begin
                mode = 0;
            end else begin
                if (br_cmd_en) begin
                    cmd_en_total++;
                    if (mode != 0) overlap_cmd++;
                    base = br_addr; t = 0; b = 0; gap_done = 0;
                    mode = (br_cmd == CMD_WRITE) ? 1 : 2;
                end else if (mode != 0) begin
                    t++;
                end
                if (mode == 1) begin
                    mem[base + AW'(t)] = br_wr_data;
                    nxt_busy = 1'b1;
                    if (t == BDC - 1) mode = 0;
                end else if (mode == 2) begin
                    nxt_busy = 1'b1;
                    if (t >= ram_lat && b < BDC) begin
                        if (ram_gap && b == 2 && !gap_done) begin
                            gap_done = 1;
                        end else begin
                            nxt_vld = !ram_mute;
                            nxt_dat = mem[base + AW'(b)];
                            b++;
                        end
                    end
                    if (b == BDC) mode = 0;
                end
            end
            @(posedge clk);
            #1;
            br_busy = nxt_busy;
            br_rd_data_valid = nxt_vld;
            br_rd_data = nxt_dat;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk1({pfx, "_req_ready"}, req_ready, 1'b0);
        chk1({pfx, "_resp_valid"}, resp_valid, 1'b0);
        chk1({pfx, "_resp_write"}, resp_write, 1'b0);
        chk1({pfx, "_resp_error"}, resp_error, 1'b0);
        chkl({pfx, "_resp_rd_line"}, resp_rd_line, '0);
        chk1({pfx, "_br_cmd_en"}, br_cmd_en, 1'b0);
        chk1({pfx, "_br_cmd"}, br_cmd, 1'b0);
        chki({pfx, "_br_addr"}, int'(br_addr), 0);
        chkd({pfx, "_br_wr_data"}, br_wr_data, '0);
        chki({pfx, "_br_data_mask"}, int'(br_data_mask), 0);
    endtask

    // Presents a request and returns its accept cycle; leaves the caller at the start of the cmd cycle.
    task automatic issue(input logic wr, input logic [LAB-1:0] a, input logic [LB-1:0] line,
                         output int acc);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wr_line = line;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
            next_cyc();
        end
        next_cyc();
        req_valid = 1'b0;
        chk1("accept_bound", (acc >= 0), 1'b1);
    endtask

    // Waits for resp_valid; on success the caller is mid-cycle in the response cycle.
    task automatic wait_resp(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                at = cyc;
                break;
            end
            next_cyc();
        end
        chk1("resp_bound", (at >= 0), 1'b1);
    endtask

    logic [LB-1:0] line1;
    logic [LB-1:0] line2;

    initial begin
        int a;
        int a1;
        int a2;
        int r;
        int seen;
        int n0;
        checks = 0; errors = 0;
        ram_lat = 6; ram_mute = 0; ram_gap = 0;
        line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line2 = {64'hDEAD_BEEF_0000_0004, 64'hCAFE_F00D_0000_0003,
                 64'h0123_4567_89AB_CDEF, 64'hA5A5_5A5A_0F0F_F0F0};
        rst_n = 1'b0; br_init_calib = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wr_line = '0;

        // Reset values
        repeat (3) next_cyc();
        @(negedge clk);
        check_reset_outputs("reset");
        next_cyc();
        rst_n = 1'b1;

        // Calibration gating
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("calib_low_ready", req_ready, 1'b0);
            chk1("calib_low_cmd_en", br_cmd_en, 1'b0);
            next_cyc();
        end
        br_init_calib = 1'b1;
        next_cyc();
        @(negedge clk);
        chk1("calib_up_ready", req_ready, 1'b1);
        next_cyc();

        // Write line 1
        issue(1'b1, 2'd1, line1, a);
        for (int k = 0; k < BDC; k++) begin
            @(negedge clk);
            chk1("wr_cmd_en", br_cmd_en, (k == 0));
            chkd("wr_beat", br_wr_data, line1[k*DW +: DW]);
            chk1("wr_ready_low", req_ready, 1'b0);
            if (k == 0) begin
                chk1("wr_cmd", br_cmd, 1'b1);
                chki("wr_addr", int'(br_addr), 4);
            end
            next_cyc();
        end
        @(negedge clk);
        chk1("wr_resp_valid", resp_valid, 1'b1);
        chk1("wr_resp_write", resp_write, 1'b1);
        chk1("wr_resp_error", resp_error, 1'b0);
        chki("wr_resp_cycle", cyc, a + 5);
        next_cyc();

        // Read line 1 back, latency 6
        issue(1'b0, 2'd1, '0, a);
        @(negedge clk);
        chk1("rd_cmd_en", br_cmd_en, 1'b1);
        chk1("rd_cmd", br_cmd, 1'b0);
        chki("rd_addr", int'(br_addr), 4);
        next_cyc();
        wait_resp(60, r);
        chki("rd_resp_cycle", r, a + 12);
        chkl("rd_line", resp_rd_line, line1);
        chk1("rd_resp_error", resp_error, 1'b0);
        chk1("rd_resp_write", resp_write, 1'b0);
        next_cyc();
        chki("cmd_count_two", cmd_en_total, 2);

        // Back-to-back write then read with req_valid held, gap inside the read burst
        n0 = cmd_en_total;
        ram_gap = 1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wr_line = line2;
        a1 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                a1 = cyc;
                break;
            end
            next_cyc();
        end
        next_cyc();
        req_write = 1'b0; req_wr_line = '0;
        seen = -1; a2 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) seen = cyc;
            if (req_ready) begin
                a2 = cyc;
                break;
            end
            next_cyc();
        end
        next_cyc();
        req_valid = 1'b0;
        chki("b2b_wr_resp_cycle", seen, a1 + 5);
        chki("b2b_second_accept", a2, a1 + 6);
        wait_resp(60, r);
        chki("b2b_rd_resp_cycle", r, a2 + 13);
        chkl("b2b_rd_line", resp_rd_line, line2);
        chk1("b2b_rd_error", resp_error, 1'b0);
        next_cyc();
        ram_gap = 0;
        chki("b2b_cmd_count", cmd_en_total - n0, 2);

        // Read timeout: RAM never raises valid
        ram_mute = 1;
        issue(1'b0, 2'd3, '0, a);
        wait_resp(60, r);
        chki("tmo_resp_cycle", r, a + 22);
        chk1("tmo_resp_error", resp_error, 1'b1);
        chk1("tmo_resp_write", resp_write, 1'b0);
        next_cyc();
        ram_mute = 0;

        // Normal service after timeout
        issue(1'b0, 2'd1, '0, a);
        wait_resp(60, r);
        chki("post_tmo_resp_cycle", r, a + 12);
        chkl("post_tmo_line", resp_rd_line, line1);
        chk1("post_tmo_error", resp_error, 1'b0);
        next_cyc();

        // Calibration drop in Idle gates req_ready combinationally
        br_init_calib = 1'b0;
        @(negedge clk);
        chk1("calib_drop_ready", req_ready, 1'b0);
        next_cyc();
        br_init_calib = 1'b1;
        @(negedge clk);
        chk1("calib_rise_ready", req_ready, 1'b1);
        next_cyc();

        // Reset in the middle of a read burst
        issue(1'b0, 2'd2, '0, a);
        repeat (8) next_cyc();
        rst_n = 1'b0; br_init_calib = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            @(negedge clk);
            chk1("midrst_no_resp", resp_valid, 1'b0);
        end
        next_cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("recal_no_resp", resp_valid, 1'b0);
            chk1("recal_ready_low", req_ready, 1'b0);
            next_cyc();
        end
        br_init_calib = 1'b1;
        next_cyc();
        issue(1'b0, 2'd2, '0, a);
        wait_resp(60, r);
        chki("recal_resp_cycle", r, a + 12);
        chkl("recal_line", resp_rd_line, line2);
        chk1("recal_error", resp_error, 1'b0);
        next_cyc();

        chki("no_overlap_cmd", overlap_cmd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
